// File: rtl/fp_add_sequencer_if.sv
// Bundle between the FFT control / write-back side and the FP add sequencer,
// plus the sequencer's link to the single-precision adder driver.
interface fp_add_sequencer_if #(
  parameter int AW = 4
);
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_a;
  logic [31:0]   ld_b;
  logic [AW:0]   len;
  logic          go;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic          add_start;
  logic [31:0]   add_r;
  logic          add_rdy;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;

  modport master (
    output ld_we, ld_addr, ld_a, ld_b, len, go, add_r, add_rdy, rd_addr,
    input  busy, done, err, add_a, add_b, add_start, rd_data
  );

  modport slave (
    input  ld_we, ld_addr, ld_a, ld_b, len, go, add_r, add_rdy, rd_addr,
    output busy, done, err, add_a, add_b, add_start, rd_data
  );
endinterface

// File: rtl/fp_add_sequencer.sv
// Issues a bank of operand pairs to the FP adder driver as start pulses separated by a
// low cycle, limits adds in flight, and stores returning results in issue order.
module fp_add_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int MAX_OUT = 8
) (
  input logic               clk,
  input logic               rst,
  fp_add_sequencer_if.slave bus
);

  localparam logic [AW:0] MAX_OUT_C = (AW+1)'(MAX_OUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [AW:0] n;
  logic [AW:0] iss;
  logic [AW:0] ret;
  logic [AW:0] out;

  logic [31:0] op_a     [DEPTH];
  logic [31:0] op_b     [DEPTH];
  logic [31:0] res_bank [DEPTH];

  logic        issue_fire;
  logic        retire_ok;
  logic        rdy_orphan;
  logic        err_q;
  logic        start_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] rd_q;

  always_comb begin
    state_nx   = state;
    issue_fire = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.go) state_nx = (bus.len == '0) ? S_FIN : S_ISSUE;
      end
      S_ISSUE: begin
        if (out < MAX_OUT_C) begin
          issue_fire = 1'b1;
          state_nx   = S_GAP;
        end
      end
      // The driver re-arms only on a low start, so every pulse is followed by this cycle.
      S_GAP: begin
        state_nx = (iss < n) ? S_ISSUE : S_DRAIN;
      end
      S_DRAIN: begin
        if (ret == n) state_nx = S_FIN;
      end
      S_FIN: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign retire_ok  = bus.add_rdy && (out != '0);
  assign rdy_orphan = bus.add_rdy && (out == '0);

  assign bus.busy      = (state == S_ISSUE) || (state == S_GAP) || (state == S_DRAIN);
  assign bus.done      = (state == S_FIN);
  assign bus.err       = err_q;
  assign bus.add_start = start_q;
  assign bus.add_a     = a_q;
  assign bus.add_b     = b_q;
  assign bus.rd_data   = rd_q;

  always_ff @(posedge clk) begin
    if (bus.ld_we) begin
      op_a[bus.ld_addr] <= bus.ld_a;
      op_b[bus.ld_addr] <= bus.ld_b;
    end
  end

  // ret < n <= DEPTH whenever something is outstanding, so the low bits address the slot.
  always_ff @(posedge clk) begin
    if (!rst && retire_ok) res_bank[ret[AW-1:0]] <= bus.add_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      n       <= '0;
      iss     <= '0;
      ret     <= '0;
      out     <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
    end else begin
      state   <= state_nx;
      start_q <= issue_fire;
      rd_q    <= res_bank[bus.rd_addr];

      if (rdy_orphan) err_q <= 1'b1;

      if (issue_fire) begin
        a_q <= op_a[iss[AW-1:0]];
        b_q <= op_b[iss[AW-1:0]];
      end

      if (state == S_IDLE && bus.go) begin
        n   <= bus.len;
        iss <= '0;
        ret <= '0;
        out <= '0;
      end else begin
        if (issue_fire) iss <= iss + 1'b1;
        if (retire_ok)  ret <= ret + 1'b1;
        if (issue_fire && !retire_ok)      out <= out + 1'b1;
        else if (!issue_fire && retire_ok) out <= out - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Bench for fp_add_sequencer: two instances (in-flight limit 8 and 2) share one adder model.
module tb_fp_add_sequencer;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    int unsigned due;
    logic [31:0] val;
  } ent_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_add_sequencer_if #(.AW(AW)) if8 ();
  fp_add_sequencer_if #(.AW(AW)) if2 ();

  fp_add_sequencer #(.DEPTH(DEPTH), .AW(AW), .MAX_OUT(8)) u_dut (.clk(clk), .rst(rst), .bus(if8));
  fp_add_sequencer #(.DEPTH(DEPTH), .AW(AW), .MAX_OUT(2)) u_thr (.clk(clk), .rst(rst), .bus(if2));

  logic          ld_we   = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_a    = '0;
  logic [31:0]   ld_b    = '0;
  logic [AW:0]   len     = '0;
  logic          go      = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          sel     = 1'b0;
  logic [31:0]   m_r     = '0;
  logic          m_rdy   = 1'b0;

  assign if8.ld_we = ld_we;     assign if2.ld_we = ld_we;
  assign if8.ld_addr = ld_addr; assign if2.ld_addr = ld_addr;
  assign if8.ld_a = ld_a;       assign if2.ld_a = ld_a;
  assign if8.ld_b = ld_b;       assign if2.ld_b = ld_b;
  assign if8.len = len;         assign if2.len = len;
  assign if8.rd_addr = rd_addr; assign if2.rd_addr = rd_addr;
  assign if8.add_r = m_r;       assign if2.add_r = m_r;
  assign if8.go = go & ~sel;    assign if2.go = go & sel;
  assign if8.add_rdy = m_rdy & ~sel;
  assign if2.add_rdy = m_rdy & sel;

  logic        s_start, s_busy, s_done, s_err;
  logic [31:0] s_a, s_b, s_rd;
  assign s_start = sel ? if2.add_start : if8.add_start;
  assign s_busy  = sel ? if2.busy      : if8.busy;
  assign s_done  = sel ? if2.done      : if8.done;
  assign s_err   = sel ? if2.err       : if8.err;
  assign s_a     = sel ? if2.add_a     : if8.add_a;
  assign s_b     = sel ? if2.add_b     : if8.add_b;
  assign s_rd    = sel ? if2.rd_data   : if8.rd_data;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Exact single-precision encoding of small non-negative integers.
  function automatic logic [31:0] int_to_fp(input int v);
    int p;
    logic [31:0] m;
    if (v <= 0) return 32'h0;
    p = 0;
    for (int k = 0; k < 23; k++) if ((v >> k) != 0) p = k;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(p + 127), m[22:0]};
  endfunction

  function automatic int fp_to_int(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'h0, 1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  // Adder model: fixed latency, in order; flushed by reset.
  int          lat      = 4;
  int unsigned cyc      = 0;
  int          spur_req = 0;
  int          spur_ack = 0;
  ent_t        pipe[$];
  ent_t        me;

  always @(posedge clk) begin
    cyc = cyc + 1;
    m_rdy <= 1'b0;
    if (rst) begin
      pipe.delete();
    end else begin
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        m_rdy <= 1'b1;
        m_r   <= 32'hDEADBEEF;
      end else if (pipe.size() > 0 && pipe[0].due <= cyc) begin
        m_rdy <= 1'b1;
        m_r   <= pipe[0].val;
        void'(pipe.pop_front());
      end
      if (s_start) begin
        me.due = cyc + int'(lat) - 1;
        me.val = int_to_fp(fp_to_int(s_a) + fp_to_int(s_b));
        pipe.push_back(me);
      end
    end
  end

  // Issue monitor: checks each start pulse against the expected operand queue.
  pair_t       issq[$];
  pair_t       ip;
  logic [31:0] resq[$];
  int          n_start = 0, n_b2b = 0, n_done = 0, inflight = 0, peak = 0;
  logic        prev_start = 1'b0;
  logic [31:0] held_a = '0, held_b = '0;

  always @(negedge clk) begin
    if (rst) begin
      inflight   = 0;
      prev_start = 1'b0;
      issq.delete();
    end else begin
      if (go && !s_busy) peak = 0;
      if (prev_start) begin
        chk("a_hold", s_a, held_a);
        chk("b_hold", s_b, held_b);
      end
      if (s_start) begin
        n_start++;
        if (prev_start) n_b2b++;
        inflight++;
        if (inflight > peak) peak = inflight;
        chk("start_expected", 32'(issq.size() != 0), 32'd1);
        if (issq.size() != 0) begin
          ip = issq.pop_front();
          chk("add_a", s_a, ip.a);
          chk("add_b", s_b, ip.b);
        end
        held_a = s_a;
        held_b = s_b;
      end
      if (m_rdy && inflight > 0) inflight--;
      if (s_done) n_done++;
      prev_start = s_start;
    end
  end

  int st0 = 0, b0 = 0, d0 = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [31:0] a, input logic [31:0] b);
    ld_we   = 1'b1;
    ld_addr = i[AW-1:0];
    ld_a    = a;
    ld_b    = b;
    tick();
    ld_we = 1'b0;
  endtask

  // Slot i gets A=(am*i+ao).0, B=(bm*i+bo).0; the sum is predicted arithmetically.
  task automatic prep(input int n, input int am, input int ao, input int bm, input int bo);
    pair_t p;
    for (int i = 0; i < n; i++) begin
      p.a = int_to_fp(am * i + ao);
      p.b = int_to_fp(bm * i + bo);
      load(i, p.a, p.b);
      issq.push_back(p);
      resq.push_back(int_to_fp((am + bm) * i + ao + bo));
    end
  endtask

  task automatic start_run(input logic s, input int n, input int l);
    sel = s;
    lat = l;
    st0 = n_start;
    b0  = n_b2b;
    d0  = n_done;
    go  = 1'b1;
    len = n[AW:0];
    tick();
    go = 1'b0;
  endtask

  task automatic finish_run(input int n, input int maxo, input bit exact_peak, input int midgo_at);
    int c;
    c = 0;
    while (n_done == d0 && c < 3000) begin
      if (c == midgo_at) begin
        go  = 1'b1;
        len = 5'd3;
      end else begin
        go = 1'b0;
      end
      tick();
      c++;
    end
    go = 1'b0;
    tick();
    tick();
    chk("done_count", 32'(n_done - d0), 32'd1);
    chk("starts", 32'(n_start - st0), 32'(n));
    chk("b2b_starts", 32'(n_b2b - b0), 32'd0);
    chk("busy_end", 32'(s_busy), 32'd0);
    chk("err_end", 32'(s_err), 32'd0);
    chk("issq_left", 32'(issq.size()), 32'd0);
    if (exact_peak) chk("peak", 32'(peak), 32'(maxo));
    else            chk("peak_le_max", 32'(peak <= maxo), 32'd1);
    for (int i = 0; i < n; i++) begin
      rd_addr = i[AW-1:0];
      tick();
      chk("result", s_rd, (resq.size() != 0) ? resq.pop_front() : 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    pair_t p;
    int    c;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(if8.busy), 32'd0);
    chk("rst_done", 32'(if8.done), 32'd0);
    chk("rst_err", 32'(if8.err), 32'd0);
    chk("rst_start", 32'(if8.add_start), 32'd0);
    chk("rst_add_a", if8.add_a, 32'd0);
    chk("rst_add_b", if8.add_b, 32'd0);
    chk("rst_rd_data", if8.rd_data, 32'd0);
    chk("rst_thr_busy", 32'(if2.busy), 32'd0);
    rst = 1'b0;
    tick();

    // 1.0 + 2.0 = 3.0
    p.a = 32'h3F800000;
    p.b = 32'h40000000;
    load(0, p.a, p.b);
    issq.push_back(p);
    resq.push_back(32'h40400000);
    start_run(1'b0, 1, 4);
    finish_run(1, 1, 1'b1, -1);

    // Full bank with a go pulse injected mid-run that must be ignored.
    prep(16, 1, 0, 0, 1);
    start_run(1'b0, 16, 11);
    finish_run(16, 8, 1'b0, 5);

    // In-flight limit of 2 against a slow adder.
    prep(5, 1, 10, 3, 0);
    start_run(1'b1, 5, 20);
    finish_run(5, 2, 1'b1, -1);

    // Zero-length run: done on the cycle after go, no start.
    sel = 1'b0;
    st0 = n_start;
    go  = 1'b1;
    len = '0;
    tick();
    go = 1'b0;
    chk("len0_done", 32'(s_done), 32'd1);
    chk("len0_busy", 32'(s_busy), 32'd0);
    tick();
    chk("len0_done_drop", 32'(s_done), 32'd0);
    chk("len0_starts", 32'(n_start - st0), 32'd0);

    // Result with nothing outstanding.
    spur_req++;
    tick();
    tick();
    chk("err_set", 32'(s_err), 32'd1);
    tick();
    tick();
    tick();
    chk("err_sticky", 32'(s_err), 32'd1);

    // Abort with three adds in flight, then a fresh run.
    prep(8, 2, 0, 0, 3);
    start_run(1'b0, 8, 20);
    c = 0;
    while ((n_start - st0) < 3 && c < 200) begin
      tick();
      c++;
    end
    chk("abort_three_issued", 32'(n_start - st0), 32'd3);
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(s_busy), 32'd0);
    chk("abort_start", 32'(s_start), 32'd0);
    chk("abort_err", 32'(s_err), 32'd0);
    rst = 1'b0;
    resq.delete();
    tick();

    prep(2, 1, 5, 1, 7);
    start_run(1'b0, 2, 6);
    finish_run(2, 8, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Upstream feeder and downstream collector for the single-precision FP adder driver.
- Holds a bank of DEPTH operand pairs loaded by the FFT control. On go, it issues each pair to the adder driver as a one-cycle start pulse.
- Results are captured on rdy into an in-order result bank, which is then read back by the butterfly write-back stage.

Parameters:
- DEPTH, 16, number of operand/result slots (power of two).
- AW, 4, address width, log2(DEPTH).
- MAX_OUT, 8, maximum adds in flight; must be at least the adder latency divided by 2, rounded up.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_we  in  1  write operand pair into slot ld_addr.
- ld_addr  in  AW  operand slot address.
- ld_a  in  32  operand A (IEEE-754 single).
- ld_b  in  32  operand B.
- len  in  AW+1  pairs to process, 0..DEPTH; sampled on go.
- go  in  1  start a run; honoured only in IDLE.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when the last result is stored.
- err  out  1  sticky; rdy seen with nothing outstanding.
- add_a  out  32  to adder driver A.
- add_b  out  32  to adder driver B.
- add_start  out  1  to adder driver start.
- add_r  in  32  adder result.
- add_rdy  in  1  adder result valid, one cycle.
- rd_addr  in  AW  result read address.
- rd_data  out  32  result bank word, registered, 1-cycle read latency.

Behaviour:
- Reset: busy=0, done=0, err=0, add_start=0, add_a=0, add_b=0, rd_data=0, state=IDLE, all counters 0. Operand and result banks are not cleared.
- rst mid-run aborts the run immediately. A late add_rdy arriving after reset while in IDLE sets err.
- States:
  - IDLE: on go, latch len into n. If n=0, go to FIN. Otherwise busy=1, iss=0, ret=0, out=0, go to ISSUE.
  - ISSUE: if out<MAX_OUT, drive add_a/add_b from slot iss and add_start=1 for exactly this cycle, then iss++, out++, go to GAP. If out=MAX_OUT, hold add_start=0 and stay.
  - GAP: add_start=0 for at least one cycle. The driver only re-arms on a low start, so back-to-back high pulses are forbidden. Next state is ISSUE if iss<n, else DRAIN.
  - DRAIN: wait until ret=n, then go to FIN.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Issue rate: at most one start every 2 cycles.
- add_a/add_b: registered, stable in the start cycle and the following cycle. They hold their last value otherwise.
- Retire: on add_rdy in any state, write add_r to result slot ret, then ret++ and out--.
  - Results are stored in issue order; the adder is in-order.
  - If add_rdy arrives with out=0, set err, discard the data, and leave counters unchanged.
- Simultaneous issue and retire in the same cycle: out is unchanged (+1 and -1).
- Counter widths: iss, ret, out are AW+1 bits. No wrap, since n≤DEPTH.
- go while busy is ignored. ld_we while busy is allowed but undefined for slots ≥ iss; the bench must not do this.
- Result bank: rd_data <= bank[rd_addr] every cycle, independent of state.
- Read-during-retire to the same address returns the old value.
- FP arithmetic is entirely inside the adder core. This block is bit-transparent.

Test Plan:
- Single add: slot0 A=0x3F800000, B=0x40000000, len=1, go.
  - Expect exactly one add_start pulse with add_a/add_b equal to those values.
  - After add_rdy with 0x40400000: result slot0=0x40400000, one done pulse, busy low.
- Full run: len=16, A=i.0, B=1.0, adder model latency 11.
  - Expect 16 start pulses, each followed by a low cycle; out never exceeds MAX_OUT.
  - Results slot i = (i+1).0 in order; done once; err=0.
- Throttle: MAX_OUT=2, latency 20, len=5.
  - Issue stalls with add_start low whenever two ops are in flight.
  - Simultaneous rdy and start cycles keep out constant; all 5 results correct.
- len=0 plus spurious go while busy:
  - len=0 gives done one cycle after go with no add_start.
  - go asserted mid-run leaves n, iss, and the output sequence unchanged.
- Error and reset:
  - add_rdy in IDLE sets err=1, which stays set.
  - rst during ISSUE with 3 outstanding returns busy=0, add_start=0, err=0 the next cycle.
  - A new run of len=2 afterwards completes correctly.
